// File: rtl/fp_norm_shifter_if.sv
// ============================================================================
// Module      : fp_norm_shifter_if
// Description : Operand/result handshake bundle for the left-normalization unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_norm_shifter_if #(
  parameter int MAN_W = 48,
  parameter int EXP_W = 10,
  parameter int SH_W  = $clog2(MAN_W + 1)
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [MAN_W-1:0] man_i;
  logic [EXP_W-1:0] exp_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [MAN_W-1:0] man_o;
  logic [EXP_W-1:0] exp_o;
  logic [SH_W-1:0]  shamt_o;
  logic             zero_o;

  // Upstream adder side plus downstream rounder side, seen from outside the unit
  modport master (
    output in_valid_i, man_i, exp_i, out_ready_i,
    input  in_ready_o, out_valid_o, man_o, exp_o, shamt_o, zero_o
  );

  modport slave (
    input  in_valid_i, man_i, exp_i, out_ready_i,
    output in_ready_o, out_valid_o, man_o, exp_o, shamt_o, zero_o
  );
endinterface

`default_nettype wire

// File: rtl/fp_norm_shifter.sv
// ============================================================================
// Module      : fp_norm_shifter
// Description : Iterative left-normalizer; stops at MSB set, exponent 1 or zero.
//               Optional 8-bit coarse stepping under `NORM_COARSE_SHIFT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_norm_shifter #(
  parameter int MAN_W = 48,
  parameter int EXP_W = 10,
  parameter int SH_W  = $clog2(MAN_W + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  fp_norm_shifter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic [MAN_W-1:0] man_r;
  logic [EXP_W-1:0] exp_r;
  logic [SH_W-1:0]  sh_r;
  logic             zero_r;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      man_r   <= '0;
      exp_r   <= '0;
      sh_r    <= '0;
      zero_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid_i) begin
            man_r   <= bus.man_i;
            exp_r   <= bus.exp_i;
            sh_r    <= '0;
            zero_r  <= 1'b0;
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          if (man_r == '0) begin
            zero_r  <= 1'b1;
            exp_r   <= '0;
            state_r <= DONE;
          end else if (man_r[MAN_W-1]) begin
            state_r <= DONE;
          end else if (exp_r <= EXP_W'(1)) begin
            // Subnormal boundary: leave the remaining leading zeros in place
            state_r <= DONE;
`ifdef NORM_COARSE_SHIFT_EN
          end else if ((man_r[MAN_W-1 -: 8] == 8'd0) && (exp_r > EXP_W'(8))) begin
            man_r <= man_r << 8;
            exp_r <= exp_r - EXP_W'(8);
            sh_r  <= sh_r + SH_W'(8);
`endif
          end else begin
            man_r <= man_r << 1;
            exp_r <= exp_r - EXP_W'(1);
            sh_r  <= sh_r + SH_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = (state_r == IDLE);
  assign bus.out_valid_o = (state_r == DONE);
  assign bus.man_o       = man_r;
  assign bus.exp_o       = exp_r;
  assign bus.shamt_o     = sh_r;
  assign bus.zero_o      = zero_r;

endmodule

`default_nettype wire

// File: tb/tb_fp_norm_shifter.sv
// Testbench for fp_norm_shifter: directed vector table, hand-written handshake
// and reset corner cases, then random operands against a leading-zero model.
`default_nettype none

module tb_fp_norm_shifter;

  localparam int MAN_W = 48;
  localparam int EXP_W = 10;
  localparam int SH_W  = $clog2(MAN_W + 1);
  localparam int MAX_WAIT = 200;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  fp_norm_shifter_if #(.MAN_W(MAN_W), .EXP_W(EXP_W), .SH_W(SH_W)) bus ();

  fp_norm_shifter #(.MAN_W(MAN_W), .EXP_W(EXP_W), .SH_W(SH_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [MAN_W-1:0] man;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] eman;
    logic [EXP_W-1:0] eexp;
    int               esh;
    bit               ez;
    int               lat_c;
    int               lat_s;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Result from the normalization rules: shift by the leading-zero count,
  // clamped so the exponent never drops below 1.
  function automatic void model(input logic [MAN_W-1:0] m, input int e,
                                output logic [MAN_W-1:0] mo, output int eo,
                                output int sh, output bit z, output int lat);
    int lz;
    int room;
    int le;
    int ll;
    int k;
    lz = 0;
    if (m == '0) begin
      mo = '0; eo = 0; sh = 0; z = 1'b1; lat = 1;
      return;
    end
    while (m[MAN_W-1-lz] == 1'b0) lz++;
    room = (e > 1) ? e - 1 : 0;
    sh   = (lz < room) ? lz : room;
    mo   = m << sh;
    eo   = e - sh;
    z    = 1'b0;
    // Step count: coarse byte steps first (when built in), then single bits
    k  = 0;
    ll = lz;
    le = e;
`ifdef NORM_COARSE_SHIFT_EN
    while (ll >= 8 && le > 8) begin
      ll -= 8; le -= 8; k++;
    end
`endif
    k  += (ll < ((le > 1) ? le - 1 : 0)) ? ll : ((le > 1) ? le - 1 : 0);
    lat = k + 1;
  endfunction

  // Issue one operand and check every result field, the latency and the
  // stability of the outputs while out_ready is held low for 'hold' cycles.
  task automatic run_op(input string tag, input logic [MAN_W-1:0] m, input logic [EXP_W-1:0] e,
                        input logic [MAN_W-1:0] em, input logic [EXP_W-1:0] ee, input int esh,
                        input bit ez, input int elat, input int hold, input bit offer);
    int j;
    @(negedge clk);
    chk({tag, " in_ready_pre"}, 64'(bus.in_ready_o), 64'd1);
    bus.in_valid_i = 1'b1;
    bus.man_i      = m;
    bus.exp_i      = e;
    bus.out_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.man_i      = '0;
    j = 0;
    while (!bus.out_valid_o && j < MAX_WAIT) begin
      @(negedge clk);
      j++;
    end
    if (!bus.out_valid_o) begin
      chk({tag, " timeout"}, 64'(j), 64'(elat));
      return;
    end
    chk({tag, " latency"}, 64'(j), 64'(elat));
    chk({tag, " man"}, 64'(bus.man_o), 64'(em));
    chk({tag, " exp"}, 64'(bus.exp_o), 64'(ee));
    chk({tag, " shamt"}, 64'(bus.shamt_o), 64'(esh));
    chk({tag, " zero"}, 64'(bus.zero_o), 64'(ez));
    for (int h = 0; h < hold; h++) begin
      if (offer) begin
        bus.in_valid_i = 1'b1;
        bus.man_i      = 48'h0000_0000_00F0;
        bus.exp_i      = 10'd300;
      end
      @(negedge clk);
      chk({tag, " hold_valid"}, 64'(bus.out_valid_o), 64'd1);
      chk({tag, " hold_man"}, 64'(bus.man_o), 64'(em));
      chk({tag, " hold_exp"}, 64'(bus.exp_o), 64'(ee));
      if (offer) chk({tag, " hold_in_ready"}, 64'(bus.in_ready_o), 64'd0);
    end
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b0;
    chk({tag, " in_ready_post"}, 64'(bus.in_ready_o), 64'd1);
    chk({tag, " valid_post"}, 64'(bus.out_valid_o), 64'd0);
    if (offer) begin
      @(negedge clk);
      chk({tag, " offer_ignored"}, 64'(bus.in_ready_o), 64'd1);
    end
  endtask

  initial begin
    logic [MAN_W-1:0] rm;
    logic [MAN_W-1:0] mo;
    int               re;
    int               eo;
    int               sh;
    bit               z;
    int               lat;

    n_checks = 0;
    n_fail   = 0;
    bus.in_valid_i  = 1'b0;
    bus.man_i       = '0;
    bus.exp_i       = '0;
    bus.out_ready_i = 1'b0;
    rst_n = 1'b0;

    vt[0] = '{48'h8000_0000_0000, 10'd100, 48'h8000_0000_0000, 10'd100, 0, 1'b0, 1, 1};
    vt[1] = '{48'h0000_0000_0001, 10'd200, 48'h8000_0000_0000, 10'd153, 47, 1'b0, 13, 48};
    vt[2] = '{48'h0000_0000_0001, 10'd5, 48'h0000_0000_0010, 10'd1, 4, 1'b0, 5, 5};
    vt[3] = '{48'h0000_0000_0000, 10'd77, 48'h0000_0000_0000, 10'd0, 0, 1'b1, 1, 1};
    vt[4] = '{48'h0000_0000_0001, 10'd9, 48'h0000_0000_0100, 10'd1, 8, 1'b0, 2, 9};
    vt[5] = '{48'h00FF_0000_0000, 10'd20, 48'hFF00_0000_0000, 10'd12, 8, 1'b0, 2, 9};
    vt[6] = '{48'h0000_0000_0123, 10'd0, 48'h0000_0000_0123, 10'd0, 0, 1'b0, 1, 1};
    vt[7] = '{48'h0000_0000_0123, 10'd1, 48'h0000_0000_0123, 10'd1, 0, 1'b0, 1, 1};

    repeat (2) @(negedge clk);
    chk("rst in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("rst out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst man", 64'(bus.man_o), 64'd0);
    chk("rst exp", 64'(bus.exp_o), 64'd0);
    chk("rst shamt", 64'(bus.shamt_o), 64'd0);
    chk("rst zero", 64'(bus.zero_o), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
`ifdef NORM_COARSE_SHIFT_EN
      run_op($sformatf("vec%0d", i), vt[i].man, vt[i].exp, vt[i].eman, vt[i].eexp,
             vt[i].esh, vt[i].ez, vt[i].lat_c, 0, 1'b0);
`else
      run_op($sformatf("vec%0d", i), vt[i].man, vt[i].exp, vt[i].eman, vt[i].eexp,
             vt[i].esh, vt[i].ez, vt[i].lat_s, 0, 1'b0);
`endif
    end

    // Back-pressure: result held for 5 cycles while a second operand is offered
    run_op("backpressure", 48'h4000_0000_0000, 10'd50, 48'h8000_0000_0000, 10'd49,
           1, 1'b0, 2, 5, 1'b1);

    // Reset in the middle of a long shift sequence
    @(negedge clk);
    bus.in_valid_i = 1'b1;
    bus.man_i      = 48'h0000_0000_0001;
    bus.exp_i      = 10'd200;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("midshift in_ready", 64'(bus.in_ready_o), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("abort in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("abort man", 64'(bus.man_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 48'h8000_0000_0000, 10'd100, 48'h8000_0000_0000, 10'd100,
           0, 1'b0, 1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rm = {$urandom(), $urandom()};
      rm = rm >> $urandom_range(0, MAN_W);
      if ($urandom_range(0, 9) == 0) rm = '0;
      re = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 1023));
      model(rm, re, mo, eo, sh, z, lat);
      run_op($sformatf("rand%0d", i), rm, EXP_W'(re), mo, EXP_W'(eo), sh, z, lat,
             int'($urandom_range(0, 2)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
